// File: rtl/clock_enabler.sv
// clock_enabler
//   Programmable clock-enable generator. While enabled, emits a one-cycle
//   strobe on `out` once every `period` clock cycles so downstream logic can
//   pace itself without leaving the single clock domain.
//
// Ports:
//   clk     in   system clock, rising-edge active
//   reset   in   synchronous, active-high reset
//   enable  in   high = count; low = freeze counter, suppress strobe
//   period  in   strobe period in cycles (unsigned); 0 disables strobing
//   out     out  registered one-cycle strobe
module clock_enabler #(
    parameter int unsigned PERIOD_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    output logic                   out
);

    localparam logic [PERIOD_BITS-1:0] ONE = PERIOD_BITS'(1);

    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic [PERIOD_BITS-1:0] terminal;

    // period - 1 is only consumed when period != 0, so its wrap at 0 is harmless.
    assign terminal = period - ONE;

    always_comb begin
        cnt_d = cnt_q;
        out_d = 1'b0;
        if (period == '0) begin
            cnt_d = '0;
        end else if (enable) begin
            // >= lets a period reduction below the current count wrap at once.
            if (cnt_q >= terminal) begin
                cnt_d = '0;
                out_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_clock_enabler.sv
module tb_clock_enabler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] period;
    logic       out;

    clock_enabler #(.PERIOD_BITS(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .period (period),
        .out    (out)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic exp_q[$];

    // Behavioural reference of the strobe generator (integer arithmetic).
    int m_cnt = 0;

    // Per-phase observations
    int ph_edges;
    int ph_pulses;
    int ph_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic start_phase();
        ph_edges  = 0;
        ph_pulses = 0;
        ph_first  = 0;
    endtask

    // Predict the output after the coming edge, push it, run the edge, compare.
    task automatic tick(input string tag);
        logic e;
        int   p;
        p = int'(period);
        e = 1'b0;
        if (reset) begin
            m_cnt = 0;
        end else if (p == 0) begin
            m_cnt = 0;
        end else if (enable) begin
            if (m_cnt + 1 >= p) begin
                m_cnt = 0;
                e = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag, {31'd0, out}, {31'd0, exp_q.pop_front()});
        ph_edges++;
        if (out === 1'b1) begin
            ph_pulses++;
            if (ph_first == 0) ph_first = ph_edges;
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        period = 8'd3;
        start_phase();
        repeat (2) tick("reset_out");
        check("reset_pulses", ph_pulses, 0);

        // Period 3 for 32 cycles
        reset = 1'b0;
        start_phase();
        repeat (32) tick("p3_out");
        check("p3_pulses", ph_pulses, 10);
        check("p3_first", ph_first, 3);

        // Switch to 5 at count 2: strobe at edge 3, then every 5
        period = 8'd5;
        start_phase();
        repeat (50) tick("p5_out");
        check("p5_pulses", ph_pulses, 10);
        check("p5_first", ph_first, 3);

        // Period 0 suppresses, restoring 5 strobes after 5 edges
        period = 8'd0;
        start_phase();
        repeat (10) tick("p0_out");
        check("p0_pulses", ph_pulses, 0);
        period = 8'd5;
        start_phase();
        repeat (10) tick("p5b_out");
        check("p5b_pulses", ph_pulses, 2);
        check("p5b_first", ph_first, 5);

        // Period 1: continuous; period 2: alternating
        period = 8'd1;
        start_phase();
        repeat (8) tick("p1_out");
        check("p1_pulses", ph_pulses, 8);
        check("p1_first", ph_first, 1);
        period = 8'd2;
        start_phase();
        repeat (8) tick("p2_out");
        check("p2_pulses", ph_pulses, 4);
        check("p2_first", ph_first, 2);

        // Period 4, freeze at count 2 for 3 cycles
        reset  = 1'b1;
        period = 8'd4;
        tick("p4_rst_out");
        reset = 1'b0;
        start_phase();
        repeat (2) tick("p4_pre_out");
        check("p4_pre_pulses", ph_pulses, 0);
        enable = 1'b0;
        start_phase();
        repeat (3) tick("p4_dis_out");
        check("p4_dis_pulses", ph_pulses, 0);
        enable = 1'b1;
        start_phase();
        repeat (4) tick("p4_re_out");
        check("p4_re_pulses", ph_pulses, 1);
        check("p4_re_first", ph_first, 2);

        // Period 8 to count 6, then drop to 3: immediate wrap
        reset = 1'b1;
        tick("p8_rst_out");
        reset  = 1'b0;
        period = 8'd8;
        start_phase();
        repeat (6) tick("p8_out");
        check("p8_pulses", ph_pulses, 0);
        period = 8'd3;
        start_phase();
        repeat (8) tick("p8to3_out");
        check("p8to3_pulses", ph_pulses, 3);
        check("p8to3_first", ph_first, 1);

        // Reset mid-count, count restarts from 0
        reset = 1'b1;
        start_phase();
        tick("midrst_out");
        check("midrst_pulses", ph_pulses, 0);
        reset = 1'b0;
        start_phase();
        repeat (6) tick("postrst_out");
        check("postrst_pulses", ph_pulses, 2);
        check("postrst_first", ph_first, 3);

        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
